// File: rtl/mem_pkg.sv
// Shared types and constants for the unified instruction/data memory responder.
package mem_pkg;

    localparam int WORD_W = 32;

    localparam logic [WORD_W-1:0] ERR_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Word-index width for a store of the given depth (at least one bit).
    function automatic int idx_w(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous word RAM: one read or one write per enabled cycle.
module mem_array
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = idx_w(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: one request at a time, fixed wait states, one-cycle response.
// Optional `MEM_ALIGN_CHECK_EN flags misaligned requests with resp_err instead of accessing the store.
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
);

    localparam int          AW        = idx_w(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_LAST = 4'(WAIT_CYCLES);

    state_t            state;
    logic [3:0]        cnt;
    logic [AW-1:0]     idx_q;
    logic [WORD_W-1:0] wdata_q;
    logic              write_q;
    logic              err_q;
    logic              resp_err_q;

    logic              accept;
    logic              go_resp;
    logic              req_err;
    logic              cur_write;
    logic              cur_err;
    logic              ram_en;
    logic              ram_we;
    logic [AW-1:0]     ram_addr;
    logic [WORD_W-1:0] ram_wdata;
    logic [WORD_W-1:0] ram_rdata;
    logic              unused_addr;

`ifdef MEM_ALIGN_CHECK_EN
    assign req_err     = |req_addr[1:0];
    assign unused_addr = ^req_addr[31:AW+2];
`else
    assign req_err     = 1'b0;
    assign unused_addr = ^{req_addr[31:AW+2], req_addr[1:0]};
`endif

    assign accept = req_valid && req_ready;

    // In IDLE the RAM is driven straight from the request so a zero-wait
    // access still lands on the edge that enters RESP.
    always_comb begin
        cur_write = write_q;
        cur_err   = err_q;
        ram_addr  = idx_q;
        ram_wdata = wdata_q;
        if (state == S_IDLE) begin
            cur_write = req_write;
            cur_err   = req_err;
            ram_addr  = req_addr[AW+1:2];
            ram_wdata = req_wdata;
        end
        go_resp = (accept && (WAIT_CYCLES == 0)) ||
                  ((state == S_WAIT) && (cnt == WAIT_LAST));
        ram_en  = go_resp && !cur_err;
        ram_we  = ram_en && cur_write;
    end

    mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            cnt        <= 4'd0;
            idx_q      <= '0;
            wdata_q    <= '0;
            write_q    <= 1'b0;
            err_q      <= 1'b0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        idx_q     <= req_addr[AW+1:2];
                        wdata_q   <= req_wdata;
                        write_q   <= req_write;
                        err_q     <= req_err;
                        req_ready <= 1'b0;
                        if (go_resp) begin
                            state      <= S_RESP;
                            resp_valid <= 1'b1;
                            resp_err_q <= req_err;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= 4'd1;
                        end
                    end
                end
                S_WAIT: begin
                    if (go_resp) begin
                        state      <= S_RESP;
                        cnt        <= 4'd0;
                        resp_valid <= 1'b1;
                        resp_err_q <= err_q;
                    end else begin
                        cnt <= 4'(cnt + 4'd1);
                    end
                end
                S_RESP: begin
                    state      <= S_IDLE;
                    resp_valid <= 1'b0;
                    resp_err_q <= 1'b0;
                    req_ready  <= 1'b1;
                end
                default: begin
                    state      <= S_IDLE;
                    cnt        <= 4'd0;
                    resp_valid <= 1'b0;
                    resp_err_q <= 1'b0;
                    req_ready  <= 1'b1;
                end
            endcase
        end
    end

    // Read data is only presented during RESP of a read; misaligned reads return the marker.
    always_comb begin
        resp_rdata = '0;
        if ((state == S_RESP) && !write_q) begin
            resp_rdata = err_q ? ERR_DATA : ram_rdata;
        end
    end

    assign resp_err = resp_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid  [2];
    logic        req_write  [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic        req_ready  [2];
    logic        resp_valid [2];
    logic [31:0] resp_rdata [2];
    logic        resp_err   [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid[0]),
        .req_write  (req_write[0]),
        .req_addr   (req_addr[0]),
        .req_wdata  (req_wdata[0]),
        .req_ready  (req_ready[0]),
        .resp_valid (resp_valid[0]),
        .resp_rdata (resp_rdata[0]),
        .resp_err   (resp_err[0])
    );

    mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid[1]),
        .req_write  (req_write[1]),
        .req_addr   (req_addr[1]),
        .req_wdata  (req_wdata[1]),
        .req_ready  (req_ready[1]),
        .resp_valid (resp_valid[1]),
        .resp_rdata (resp_rdata[1]),
        .resp_err   (resp_err[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete transaction; lat counts cycles from acceptance to the resp_valid cycle.
    task automatic xact(input int s, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rd,
                        output logic er, output int lat);
        bit got;
        got = 0;
        lat = 0;
        rd  = '0;
        er  = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 20 && !req_ready[s]; i++) @(negedge clk);
        req_valid[s] = 1'b1;
        req_write[s] = wr;
        req_addr[s]  = addr;
        req_wdata[s] = wdata;
        @(negedge clk);
        req_valid[s] = 1'b0;
        for (int i = 1; i <= 20 && !got; i++) begin
            if (resp_valid[s]) begin
                got = 1;
                lat = i;
                rd  = resp_rdata[s];
                er  = resp_err[s];
            end else begin
                @(negedge clk);
            end
        end
        if (!got) check("resp_timeout", 32'd0, 32'd1);
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          acc [2][2];
    int          nacc [2];
    int          low [2];

    initial begin
        for (int s = 0; s < 2; s++) begin
            req_valid[s] = 1'b0;
            req_write[s] = 1'b0;
            req_addr[s]  = '0;
            req_wdata[s] = '0;
        end

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_ready",  32'(req_ready[0]),  32'd1);
        check("rst_rvalid", 32'(resp_valid[0]), 32'd0);
        check("rst_rdata",  resp_rdata[0],      32'd0);
        check("rst_err",    32'(resp_err[0]),   32'd0);
        reset_n = 1'b1;

        // Write then read, latency WAIT_CYCLES+1
        xact(0, 1'b1, 32'h10, 32'h1234_5678, rd, er, lat);
        check("wr_lat",   32'(lat), 32'd3);
        check("wr_rdata", rd,       32'd0);
        xact(0, 1'b0, 32'h10, 32'h0, rd, er, lat);
        check("rd_lat",   32'(lat), 32'd3);
        check("rd_data",  rd,       32'h1234_5678);
        @(negedge clk);
        check("resp_pulse_end", 32'(resp_valid[0]), 32'd0);
        check("idle_rdata",     resp_rdata[0],      32'd0);

        // Address wrap modulo DEPTH_WORDS*4
        xact(0, 1'b1, 32'h0000_0404, 32'hA5A5_A5A5, rd, er, lat);
        xact(0, 1'b0, 32'h0000_0004, 32'h0, rd, er, lat);
        check("wrap_data", rd, 32'hA5A5_A5A5);
        xact(0, 1'b0, 32'h0000_0010, 32'h0, rd, er, lat);
        check("wrap_keep", rd, 32'h1234_5678);

        // Zero-wait instance
        xact(1, 1'b1, 32'h30, 32'hCAFE_0001, rd, er, lat);
        check("w0_wr_lat", 32'(lat), 32'd1);
        xact(1, 1'b0, 32'h30, 32'h0, rd, er, lat);
        check("w0_rd_lat",  32'(lat), 32'd1);
        check("w0_rd_data", rd,       32'hCAFE_0001);

        // Back-to-back with req_valid held high on both instances
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            nacc[s] = 0;
            low[s]  = 0;
            req_valid[s] = 1'b1;
            req_write[s] = 1'b0;
            req_addr[s]  = 32'h10;
        end
        for (int c = 0; c < 12; c++) begin
            for (int s = 0; s < 2; s++) begin
                if (req_ready[s]) begin
                    if (nacc[s] < 2) acc[s][nacc[s]] = c;
                    nacc[s]++;
                end else if (nacc[s] == 1) begin
                    low[s]++;
                end
            end
            @(negedge clk);
        end
        for (int s = 0; s < 2; s++) req_valid[s] = 1'b0;
        repeat (5) @(negedge clk);
        check("b2b_interval_w2", 32'(acc[0][1] - acc[0][0]), 32'd4);
        check("b2b_busy_w2",     32'(low[0]),                32'd3);
        check("b2b_interval_w0", 32'(acc[1][1] - acc[1][0]), 32'd2);
        check("b2b_busy_w0",     32'(low[1]),                32'd1);

        // Reset mid-WAIT drops a pending write
        xact(0, 1'b1, 32'h20, 32'h0BAD_F00D, rd, er, lat);
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_write[0] = 1'b1;
        req_addr[0]  = 32'h20;
        req_wdata[0] = 32'hFFFF_FFFF;
        @(negedge clk);
        req_valid[0] = 1'b0;
        reset_n = 1'b0;
        #1;
        check("midrst_ready",  32'(req_ready[0]),  32'd1);
        check("midrst_rvalid", 32'(resp_valid[0]), 32'd0);
        lat = 0;
        repeat (3) begin
            @(negedge clk);
            if (resp_valid[0]) lat++;
        end
        check("midrst_no_resp", 32'(lat), 32'd0);
        reset_n = 1'b1;
        xact(0, 1'b0, 32'h20, 32'h0, rd, er, lat);
        check("midrst_data", rd, 32'h0BAD_F00D);

        // Misaligned accesses
        xact(0, 1'b1, 32'h0, 32'h1111_2222, rd, er, lat);
        check("al_wr0_err", 32'(er), 32'd0);
        xact(0, 1'b0, 32'h2, 32'h0, rd, er, lat);
        check("al_rd_lat", 32'(lat), 32'd3);
`ifdef MEM_ALIGN_CHECK_EN
        check("al_rd_err",  32'(er), 32'd1);
        check("al_rd_data", rd,      32'hDEAD_BEEF);
`else
        check("al_rd_err",  32'(er), 32'd0);
        check("al_rd_data", rd,      32'h1111_2222);
`endif
        xact(0, 1'b1, 32'h1, 32'h9999_9999, rd, er, lat);
        xact(0, 1'b0, 32'h0, 32'h0, rd, er, lat);
        check("al_word0_err", 32'(er), 32'd0);
`ifdef MEM_ALIGN_CHECK_EN
        check("al_word0", rd, 32'h1111_2222);
`else
        check("al_word0", rd, 32'h9999_9999);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
